mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 2: SRAM strobe cycles per access, legal range 1..15.
REQ-002 SHALL have parameter FLASH_WAIT, default 8: flash strobe cycles per half-word, legal range 1..31.
REQ-003 SHALL have parameter RAM_AW, default 20: SRAM word-address width.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have CPU-side ports:
- req in 1, we in 1, addr in 32 (byte address), be in 4, wdata in 32.
- ack out 1, rdata out 32.
REQ-007 SHALL have a base SRAM port (prefix base_) and an ext SRAM port (prefix ext_), each with:
- _addr out RAM_AW, _be_n out 4, _ce_n out 1, _oe_n out 1, _we_n out 1.
- _dq_o out 32, _dq_oe out 1, _dq_i in 32.
REQ-008 SHALL have flash ports flash_a out 23, flash_ce_n out 1, flash_oe_n out 1, flash_d_i in 16.

Function
REQ-009 SHALL decode the address as follows:
- addr[31:28]==4'h1 selects flash.
- Otherwise addr[22]=0 selects base and addr[22]=1 selects ext.
- SRAM word address is addr[RAM_AW+1:2].
REQ-010 SHALL implement FSM states IDLE, RAM_ACC, RAM_REC, FL_LO, FL_HI, DONE.
REQ-011 SHALL sample req only in IDLE, and SHALL latch addr, we, be and wdata on acceptance.
REQ-012 SHALL complete an accepted transaction even if req falls. The requester holds req until ack; one transaction is outstanding at a time.
REQ-013 SRAM read SHALL drive _ce_n=0 and _oe_n=0 for exactly WAIT_CYC cycles, register _dq_i on the last cycle, then enter DONE. Ack occurs WAIT_CYC+1 cycles after acceptance.
REQ-014 SRAM write SHALL:
- drive _ce_n=0, _we_n=0, _dq_oe=1 and _be_n=~be for WAIT_CYC cycles;
- then spend one RAM_REC cycle with _we_n=1, _dq_oe=1 and data held;
- then enter DONE. Ack occurs WAIT_CYC+2 cycles after acceptance.
REQ-015 _dq_oe SHALL be 1 only during RAM_ACC and RAM_REC of a write to that bank. It SHALL never be 1 while the same bank's _oe_n=0.
REQ-016 Flash read SHALL:
- read half-word at flash_a={addr[22:2],1'b0} for FLASH_WAIT cycles (FL_LO) into rdata[15:0];
- then read flash_a+1 for FLASH_WAIT cycles (FL_HI) into rdata[31:16].
Ack occurs 2*FLASH_WAIT+1 cycles after acceptance.
REQ-017 Flash writes SHALL be ignored: the FSM goes IDLE->DONE, ack follows, and no flash strobe toggles.
REQ-018 ack SHALL be a one-cycle pulse in DONE. rdata SHALL hold its value until the next read completes. The FSM SHALL return to IDLE after DONE.
REQ-019 The unselected device SHALL keep ce_n, oe_n and we_n at 1 and dq_oe at 0 throughout.
REQ-020 Wait counters SHALL be sized from WAIT_CYC and FLASH_WAIT and SHALL not wrap within a phase.

Reset
REQ-021 While rst_n=0, outputs SHALL be forced asynchronously as follows:
- all _ce_n, _oe_n, _we_n and _be_n = all ones;
- _dq_oe=0, ack=0, rdata=0;
- addresses = 0;
- FSM = IDLE.
REQ-022 Reset asserted mid-transaction SHALL abort it with no ack. A request held across rst_n release SHALL be accepted on the first clock after release.

Configuration
REQ-023 With MEM_BUS_FLASH_EN defined, flash decode and the FL_LO/FL_HI states SHALL exist.
REQ-024 Without MEM_BUS_FLASH_EN:
- flash_ce_n and flash_oe_n SHALL tie to 1 and flash_a to 0;
- addr[31:28]==4'h1 reads SHALL return 32'h0 and writes SHALL be ignored;
- either access SHALL ack at the DONE timing, one cycle after acceptance.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the region-select enum (BASE, EXT, FLASH) and the constant FLASH_REGION=4'h1.
REQ-026 The SRAM strobe/tristate timing SHALL live in one sub-module, sram_port, instantiated twice.

Verification
REQ-027 With WAIT_CYC=2, write 32'hDEADBEEF to 32'h0000_0010 (be=4'hF) -> base_we_n low for 2 cycles, base_addr=4, ack at cycle 4 after acceptance, ext strobes idle.
REQ-028 Read 32'h0040_0010 with ext_dq_i=32'h12345678 -> ext_oe_n low for 2 cycles, rdata=32'h12345678, ack at cycle 3, base_dq_oe=0 throughout.
REQ-029 With FLASH_WAIT=8 and MEM_BUS_FLASH_EN defined, read 32'h1000_0008 with half-words 16'hBEEF then 16'hDEAD -> flash_a=4 then 5, rdata=32'hDEADBEEF, ack at cycle 17.
REQ-030 Write with be=4'b0101 -> base_be_n=4'b1010 during the strobe; a following read leaves base_be_n=4'b0000.
REQ-031 Assert rst_n=0 mid SRAM write -> we_n=1 and dq_oe=0 immediately, no ack; a retried request completes normally.
REQ-032 Without MEM_BUS_FLASH_EN, read 32'h1000_0000 -> rdata=0, ack at cycle 1, flash_ce_n stays 1.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for mem_bus_ctrl: FSM states, region select, flash region code
// and the helpers used to size the wait counter and decode the CPU address.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAM_ACC = 3'd1,
    RAM_REC = 3'd2,
    FL_LO   = 3'd3,
    FL_HI   = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    BASE  = 2'd0,
    EXT   = 2'd1,
    FLASH = 2'd2
  } region_e;

  localparam logic [3:0] FLASH_REGION = 4'h1;

  // Bits needed to count 0..max(a,b)-1 within one phase.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  // Top nibble picks flash, otherwise bit 22 picks the SRAM bank.
  function automatic region_e decode(input logic [31:0] a);
    if (a[31:28] == FLASH_REGION) return FLASH;
    else if (a[22])               return EXT;
    else                          return BASE;
  endfunction

endpackage

// File: rtl/sram_port.sv
// One async SRAM bank: turns the controller phase (access / recovery) into
// active-low strobes and the data-bus tristate enable. Purely combinational,
// so every pin follows the registered controller state.
module sram_port #(
  parameter int AW = 20
) (
  input  logic          sel_i,
  input  logic          acc_i,
  input  logic          rec_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    be_n_o,
  output logic          ce_n_o,
  output logic          oe_n_o,
  output logic          we_n_o,
  output logic [31:0]   dq_o,
  output logic          dq_oe_o
);

  // Strobe decode: oe_n only on reads and dq_oe only on writes, so the bank
  // never sees both drivers on the bus at once.
  always_comb begin
    ram_addr_o = addr_i;
    dq_o       = wdata_i;
    ce_n_o     = ~(sel_i & (acc_i | rec_i));
    oe_n_o     = ~(sel_i & acc_i & ~we_i);
    we_n_o     = ~(sel_i & acc_i & we_i);
    dq_oe_o    = sel_i & we_i & (acc_i | rec_i);
    if (sel_i && (acc_i || rec_i)) be_n_o = we_i ? ~be_i : 4'h0;
    else                           be_n_o = 4'hF;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU to base SRAM / ext SRAM / 16-bit flash bus controller.
// Optional feature macro: MEM_BUS_FLASH_EN enables flash reads (FL_LO/FL_HI);
// without it the flash region reads as zero and ignores writes.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int WAIT_CYC   = 2,
  parameter int FLASH_WAIT = 8,
  parameter int RAM_AW     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic [RAM_AW-1:0] base_addr,
  output logic [3:0]        base_be_n,
  output logic              base_ce_n,
  output logic              base_oe_n,
  output logic              base_we_n,
  output logic [31:0]       base_dq_o,
  output logic              base_dq_oe,
  input  logic [31:0]       base_dq_i,
  output logic [RAM_AW-1:0] ext_addr,
  output logic [3:0]        ext_be_n,
  output logic              ext_ce_n,
  output logic              ext_oe_n,
  output logic              ext_we_n,
  output logic [31:0]       ext_dq_o,
  output logic              ext_dq_oe,
  input  logic [31:0]       ext_dq_i,
  output logic [22:0]       flash_a,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  input  logic [15:0]       flash_d_i
);

  localparam int CNT_W = cnt_width(WAIT_CYC, FLASH_WAIT);
  localparam logic [CNT_W-1:0] RAM_LAST = CNT_W'(WAIT_CYC - 1);
`ifdef MEM_BUS_FLASH_EN
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(FLASH_WAIT - 1);
`endif

  state_e            state_q, state_d;
  region_e           region_q, region_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ram_acc, ram_rec, sel_base, sel_ext;

  // Only part of the latched address reaches the pins.
  logic unused_addr;
  assign unused_addr = ^addr_q;

  // State and transaction registers; reset clears everything so all strobes go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      region_q <= BASE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next state: accept in IDLE, count each phase, capture read data on its last cycle.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = addr;
          we_d     = we;
          be_d     = be;
          wdata_d  = wdata;
          region_d = decode(addr);
          cnt_d    = '0;
          if (decode(addr) == FLASH) begin
`ifdef MEM_BUS_FLASH_EN
            state_d = we ? DONE : FL_LO;
`else
            state_d = DONE;
            if (!we) rdata_d = '0;
`endif
          end else begin
            state_d = RAM_ACC;
          end
        end
      end
      RAM_ACC: begin
        if (cnt_q == RAM_LAST) begin
          cnt_d = '0;
          if (we_q) begin
            state_d = RAM_REC;
          end else begin
            state_d = DONE;
            rdata_d = (region_q == EXT) ? ext_dq_i : base_dq_i;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RAM_REC: state_d = DONE;
`ifdef MEM_BUS_FLASH_EN
      FL_LO: begin
        if (cnt_q == FL_LAST) begin
          cnt_d         = '0;
          rdata_d[15:0] = flash_d_i;
          state_d       = FL_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FL_HI: begin
        if (cnt_q == FL_LAST) begin
          cnt_d          = '0;
          rdata_d[31:16] = flash_d_i;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    ack      = (state_q == DONE);
    ram_acc  = (state_q == RAM_ACC);
    ram_rec  = (state_q == RAM_REC);
    sel_base = (region_q == BASE);
    sel_ext  = (region_q == EXT);
`ifdef MEM_BUS_FLASH_EN
    flash_ce_n = ~((state_q == FL_LO) || (state_q == FL_HI));
    flash_oe_n = ~((state_q == FL_LO) || (state_q == FL_HI));
    flash_a    = {1'b0, addr_q[22:2], (state_q == FL_HI)};
`else
    flash_ce_n = 1'b1;
    flash_oe_n = 1'b1;
    flash_a    = '0;
`endif
  end

`ifndef MEM_BUS_FLASH_EN
  // Flash data bus has no reader in this build.
  logic unused_flash;
  assign unused_flash = ^flash_d_i;
`endif

  assign rdata = rdata_q;

  sram_port #(.AW(RAM_AW)) u_base (
    .sel_i      (sel_base),
    .acc_i      (ram_acc),
    .rec_i      (ram_rec),
    .we_i       (we_q),
    .be_i       (be_q),
    .addr_i     (addr_q[RAM_AW+1:2]),
    .wdata_i    (wdata_q),
    .ram_addr_o (base_addr),
    .be_n_o     (base_be_n),
    .ce_n_o     (base_ce_n),
    .oe_n_o     (base_oe_n),
    .we_n_o     (base_we_n),
    .dq_o       (base_dq_o),
    .dq_oe_o    (base_dq_oe)
  );

  sram_port #(.AW(RAM_AW)) u_ext (
    .sel_i      (sel_ext),
    .acc_i      (ram_acc),
    .rec_i      (ram_rec),
    .we_i       (we_q),
    .be_i       (be_q),
    .addr_i     (addr_q[RAM_AW+1:2]),
    .wdata_i    (wdata_q),
    .ram_addr_o (ext_addr),
    .be_n_o     (ext_be_n),
    .ce_n_o     (ext_ce_n),
    .oe_n_o     (ext_oe_n),
    .we_n_o     (ext_we_n),
    .dq_o       (ext_dq_o),
    .dq_oe_o    (ext_dq_oe)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (WAIT_CYC=2, FLASH_WAIT=8, RAM_AW=20).
// Flash checks depend on whether MEM_BUS_FLASH_EN is defined for the build.
module tb_mem_bus_ctrl;

  localparam int WAIT_CYC   = 2;
  localparam int FLASH_WAIT = 8;
  localparam int RAM_AW     = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req, we, ack;
  logic [31:0]       addr, wdata, rdata;
  logic [3:0]        be;
  logic [RAM_AW-1:0] base_addr, ext_addr;
  logic [3:0]        base_be_n, ext_be_n;
  logic              base_ce_n, base_oe_n, base_we_n, base_dq_oe;
  logic              ext_ce_n, ext_oe_n, ext_we_n, ext_dq_oe;
  logic [31:0]       base_dq_o, base_dq_i, ext_dq_o, ext_dq_i;
  logic [22:0]       flash_a;
  logic              flash_ce_n, flash_oe_n;
  logic [15:0]       flash_d_i;

  always #5 clk = ~clk;

  // Flash model: two fixed half-words at half-word addresses 4 and 5.
  assign flash_d_i = (flash_a == 23'd4) ? 16'hBEEF :
                     (flash_a == 23'd5) ? 16'hDEAD : 16'h0000;

  mem_bus_ctrl #(.WAIT_CYC(WAIT_CYC), .FLASH_WAIT(FLASH_WAIT), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .ack(ack), .rdata(rdata),
    .base_addr(base_addr), .base_be_n(base_be_n), .base_ce_n(base_ce_n),
    .base_oe_n(base_oe_n), .base_we_n(base_we_n), .base_dq_o(base_dq_o),
    .base_dq_oe(base_dq_oe), .base_dq_i(base_dq_i),
    .ext_addr(ext_addr), .ext_be_n(ext_be_n), .ext_ce_n(ext_ce_n),
    .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n), .ext_dq_o(ext_dq_o),
    .ext_dq_oe(ext_dq_oe), .ext_dq_i(ext_dq_i),
    .flash_a(flash_a), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_d_i(flash_d_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-transaction observations, filled by run_txn.
  int                ack_cyc, ack_n, b_we_lo, b_oe_lo, b_ce_lo, b_dqoe;
  int                e_we_lo, e_oe_lo, e_ce_lo, e_dqoe, fl_lo, overlap;
  logic [3:0]        b_be_seen;
  logic [RAM_AW-1:0] b_addr_seen, e_addr_seen;
  logic [31:0]       b_dq_seen, e_dq_seen, rd_seen;
  logic [22:0]       fl_a_lo, fl_a_hi;

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
  endtask

  // Inputs already set; the next posedge is the acceptance edge and the
  // first negedge after it is cycle 1. Runs two cycles past ack to catch extras.
  task automatic run_txn(input string name, input bit hold);
    ack_cyc = -1; ack_n = 0; overlap = 0; fl_lo = 0;
    b_we_lo = 0; b_oe_lo = 0; b_ce_lo = 0; b_dqoe = 0;
    e_we_lo = 0; e_oe_lo = 0; e_ce_lo = 0; e_dqoe = 0;
    b_be_seen = 4'hF; b_addr_seen = '1; e_addr_seen = '1;
    b_dq_seen = '1; e_dq_seen = '1; rd_seen = '1; fl_a_lo = '1; fl_a_hi = '1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      if (!base_we_n) b_we_lo++;
      if (!base_oe_n) b_oe_lo++;
      if (base_dq_oe) b_dqoe++;
      if (!base_ce_n) begin
        b_ce_lo++; b_be_seen = base_be_n; b_addr_seen = base_addr; b_dq_seen = base_dq_o;
      end
      if (!ext_we_n) e_we_lo++;
      if (!ext_oe_n) e_oe_lo++;
      if (ext_dq_oe) e_dqoe++;
      if (!ext_ce_n) begin
        e_ce_lo++; e_addr_seen = ext_addr; e_dq_seen = ext_dq_o;
      end
      if (!flash_ce_n || !flash_oe_n) fl_lo++;
      if (c == 1) fl_a_lo = flash_a;
      if (c == FLASH_WAIT + 1) fl_a_hi = flash_a;
      if ((base_dq_oe && !base_oe_n) || (ext_dq_oe && !ext_oe_n)) overlap++;
      if (ack) begin
        ack_n++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          rd_seen = rdata;
        end
        req = 1'b0;
      end
      if (ack_cyc >= 0 && c >= ack_cyc + 2) break;
    end
    $display("txn %s: ack at cycle %0d, acks %0d, rdata %h", name, ack_cyc, ack_n, rd_seen);
  endtask

  int rst_acks;

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    base_dq_i = '0; ext_dq_i = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_ack",        32'(ack), 32'd0);
    check_eq("rst_base_ce_n",  32'(base_ce_n), 32'd1);
    check_eq("rst_base_we_n",  32'(base_we_n), 32'd1);
    check_eq("rst_base_be_n",  32'(base_be_n), 32'hF);
    check_eq("rst_ext_dq_oe",  32'(ext_dq_oe), 32'd0);
    check_eq("rst_rdata",      rdata, 32'd0);
    check_eq("rst_base_addr",  32'(base_addr), 32'd0);
    check_eq("rst_flash_ce_n", 32'(flash_ce_n), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write to base bank
    drive(1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF);
    run_txn("wr_base", 1'b1);
    check_eq("wr_ack_cyc",   32'(ack_cyc), 32'd4);
    check_eq("wr_ack_n",     32'(ack_n), 32'd1);
    check_eq("wr_we_lo",     32'(b_we_lo), 32'd2);
    check_eq("wr_addr",      32'(b_addr_seen), 32'd4);
    check_eq("wr_dq",        b_dq_seen, 32'hDEADBEEF);
    check_eq("wr_dq_oe",     32'(b_dqoe), 32'd3);
    check_eq("wr_be_n",      32'(b_be_seen), 32'h0);
    check_eq("wr_ext_ce",    32'(e_ce_lo), 32'd0);
    check_eq("wr_ext_we",    32'(e_we_lo), 32'd0);
    check_eq("wr_ext_dq_oe", 32'(e_dqoe), 32'd0);

    // Read from ext bank
    ext_dq_i = 32'h12345678;
    drive(1'b0, 32'h0040_0010, 4'hF, 32'h0);
    run_txn("rd_ext", 1'b1);
    check_eq("rd_ack_cyc",   32'(ack_cyc), 32'd3);
    check_eq("rd_oe_lo",     32'(e_oe_lo), 32'd2);
    check_eq("rd_rdata",     rd_seen, 32'h12345678);
    check_eq("rd_addr",      32'(e_addr_seen), 32'd4);
    check_eq("rd_ext_dq_oe", 32'(e_dqoe), 32'd0);
    check_eq("rd_base_dqoe", 32'(b_dqoe), 32'd0);
    check_eq("rd_base_ce",   32'(b_ce_lo), 32'd0);
    check_eq("rd_overlap",   32'(overlap), 32'd0);

    // Partial write: byte enables inverted on the pins, rdata untouched
    drive(1'b1, 32'h0000_0020, 4'b0101, 32'h11223344);
    run_txn("wr_be", 1'b1);
    check_eq("wrbe_be_n",    32'(b_be_seen), 32'hA);
    check_eq("wrbe_ack_cyc", 32'(ack_cyc), 32'd4);
    check_eq("wrbe_rd_hold", rdata, 32'h12345678);

    // Base read with req pulsed only for acceptance
    base_dq_i = 32'hCAFEF00D;
    drive(1'b0, 32'h0000_0020, 4'b0101, 32'h0);
    run_txn("rd_base_pulse", 1'b0);
    check_eq("rdb_be_n",    32'(b_be_seen), 32'h0);
    check_eq("rdb_rdata",   rd_seen, 32'hCAFEF00D);
    check_eq("rdb_ack_cyc", 32'(ack_cyc), 32'd3);
    check_eq("rdb_ack_n",   32'(ack_n), 32'd1);
    check_eq("rdb_oe_lo",   32'(b_oe_lo), 32'd2);
    check_eq("rdb_addr",    32'(b_addr_seen), 32'd8);

`ifdef MEM_BUS_FLASH_EN
    drive(1'b0, 32'h1000_0008, 4'hF, 32'h0);
    run_txn("rd_flash", 1'b1);
    check_eq("fl_a_lo",    32'(fl_a_lo), 32'd4);
    check_eq("fl_a_hi",    32'(fl_a_hi), 32'd5);
    check_eq("fl_rdata",   rd_seen, 32'hDEADBEEF);
    check_eq("fl_ack_cyc", 32'(ack_cyc), 32'd17);
    check_eq("fl_strobe",  32'(fl_lo), 32'd16);
    check_eq("fl_sram_ce", 32'(b_ce_lo + e_ce_lo), 32'd0);
    drive(1'b1, 32'h1000_0008, 4'hF, 32'h55AA55AA);
    run_txn("wr_flash", 1'b1);
    check_eq("flw_ack_cyc", 32'(ack_cyc), 32'd1);
    check_eq("flw_strobe",  32'(fl_lo), 32'd0);
    check_eq("flw_rd_hold", rdata, 32'hDEADBEEF);
`else
    drive(1'b0, 32'h1000_0000, 4'hF, 32'h0);
    run_txn("rd_flash_off", 1'b1);
    check_eq("fl_rdata",   rd_seen, 32'h0);
    check_eq("fl_ack_cyc", 32'(ack_cyc), 32'd1);
    check_eq("fl_strobe",  32'(fl_lo), 32'd0);
    check_eq("fl_sram_ce", 32'(b_ce_lo + e_ce_lo), 32'd0);
    drive(1'b1, 32'h1000_0000, 4'hF, 32'h55AA55AA);
    run_txn("wr_flash_off", 1'b1);
    check_eq("flw_ack_cyc", 32'(ack_cyc), 32'd1);
    check_eq("flw_strobe",  32'(fl_lo), 32'd0);
    check_eq("flw_sram_we", 32'(b_we_lo + e_we_lo), 32'd0);
`endif

    // Reset in the middle of a base write, then retry with req held
    drive(1'b1, 32'h0000_0030, 4'hF, 32'hA5A5A5A5);
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_we_n_pre", 32'(base_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_we_n",  32'(base_we_n), 32'd1);
    check_eq("mid_dq_oe", 32'(base_dq_oe), 32'd0);
    check_eq("mid_be_n",  32'(base_be_n), 32'hF);
    check_eq("mid_rdata", rdata, 32'd0);
    rst_acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) rst_acks++;
    end
    check_eq("mid_no_ack", 32'(rst_acks), 32'd0);
    rst_n = 1'b1;
    run_txn("wr_retry", 1'b1);
    check_eq("retry_ack_cyc", 32'(ack_cyc), 32'd4);
    check_eq("retry_we_lo",   32'(b_we_lo), 32'd2);
    check_eq("retry_addr",    32'(b_addr_seen), 32'd12);
    check_eq("retry_dq",      b_dq_seen, 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
